// File: rtl/uart_resp_tx_pkg.sv
// Shared definitions for the UART response path: defaults, FSM encoding and
// parameter legality helpers (also usable by the receiver side).
package uart_resp_tx_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 234;  // 27 MHz / 115200
    localparam int unsigned UART_FIFO_DEPTH   = 16;
    localparam int unsigned UART_STOP_BITS    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic stop_bits_legal(input int unsigned n);
        return (n == 1) || (n == 2);
    endfunction

    function automatic logic clks_per_bit_legal(input int unsigned n);
        return (n >= 4) && (n <= 65535);
    endfunction

    function automatic logic fifo_depth_legal(input int unsigned d);
        return (d >= 2) && (d <= 256) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_resp_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clkin, reset_n       clock and asynchronous active-low reset
//   push_valid/push_data write request; accepted when not full or popping
//   pop                  consume the head entry (ignored when empty)
//   rd_data              head entry, valid whenever empty=0
//   full/empty/level     occupancy, combinational from the pointers
//   overflow             sticky: a push was dropped
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clkin,
    input  logic                     reset_n,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    always_comb begin
        push_ok    = push_valid && (!full || pop);
        pop_ok     = pop && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_valid && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clkin) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Host-bound UART transmitter: queues response bytes and sends them as
// 8N1 frames (1 or 2 stop bits), LSB first, back to back when queued.
// Ports:
//   clkin, reset_n   clock and asynchronous active-low reset
//   push_valid       enqueue push_data this cycle
//   push_data        byte to transmit
//   fifo_full        FIFO holds FIFO_DEPTH bytes
//   fifo_level       bytes queued (excludes the byte on the wire)
//   overflow         sticky: a push was dropped
//   tx_busy          frame in progress or FIFO non-empty
//   uart_tx          registered serial output, idle high
module uart_resp_tx
    import uart_resp_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH,
    parameter int unsigned STOP_BITS    = UART_STOP_BITS
) (
    input  logic                            clkin,
    input  logic                            reset_n,
    input  logic                            push_valid,
    input  logic [7:0]                      push_data,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            tx_busy,
    output logic                            uart_tx
);

    localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned BAUD_W    = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
    localparam logic [BAUD_W-1:0] BIT_RELOAD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_RELOAD = BAUD_W'(STOP_CLKS - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);

    // Elaboration-time parameter checks.
    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $error("uart_resp_tx: STOP_BITS must be 1 or 2");
    end
    if (!clks_per_bit_legal(CLKS_PER_BIT)) begin : g_bad_clks_per_bit
        $error("uart_resp_tx: CLKS_PER_BIT must be 4..65535");
    end
    if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_fifo_depth
        $error("uart_resp_tx: FIFO_DEPTH must be a power of two in 2..256");
    end

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              uart_tx_q, uart_tx_d;

    logic              pop;
    logic              baud_done;
    logic [7:0]        fifo_rd_data;
    logic              fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .pop        (pop),
        .rd_data    (fifo_rd_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .overflow   (overflow)
    );

    assign baud_done = (baud_q == '0);
    assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_tx   = uart_tx_q;

    // Frame sequencer; the line level is derived from the next state so the
    // start bit appears on the same edge that pops the byte.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        uart_tx_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    baud_d  = BIT_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d    = BIT_RELOAD;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_idx_q == 3'd7) begin
                        baud_d  = STOP_RELOAD;
                        state_d = ST_STOP;
                    end else begin
                        baud_d    = BIT_RELOAD;
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        baud_d  = BIT_RELOAD;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unique case (state_d)
            ST_START: uart_tx_d = 1'b0;
            ST_DATA:  uart_tx_d = shift_d[0];
            default:  uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
        end
    end

endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: two instances (1 and 2 stop bits) driven by
// directed and random pushes; a frame-level timing model predicts the
// line and flags every cycle, and a line decoder checks bytes against a
// scoreboard of accepted pushes.
module tb_uart_resp_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic             clkin = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       push_valid = '0;
    logic [1:0][7:0]  push_data = '0;
    logic [1:0]       fifo_full;
    logic [1:0][2:0]  fifo_level;
    logic [1:0]       overflow;
    logic [1:0]       tx_busy;
    logic [1:0]       uart_tx;

    always #5 clkin = ~clkin;

    uart_resp_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .STOP_BITS(1)) u_dut0 (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .push_valid (push_valid[0]),
        .push_data  (push_data[0]),
        .fifo_full  (fifo_full[0]),
        .fifo_level (fifo_level[0]),
        .overflow   (overflow[0]),
        .tx_busy    (tx_busy[0]),
        .uart_tx    (uart_tx[0])
    );

    uart_resp_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .STOP_BITS(2)) u_dut1 (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .push_valid (push_valid[1]),
        .push_data  (push_data[1]),
        .fifo_full  (fifo_full[1]),
        .fifo_level (fifo_level[1]),
        .overflow   (overflow[1]),
        .tx_busy    (tx_busy[1]),
        .uart_tx    (uart_tx[1])
    );

    // Reference model: queued bytes plus cycles left in the current frame.
    logic [7:0] m_buf [2][D];
    int         m_head [2] = '{0, 0};
    int         m_cnt  [2] = '{0, 0};
    int         m_cyc  [2] = '{0, 0};
    logic [7:0] m_cur  [2];
    logic       m_ovf  [2] = '{1'b0, 1'b0};

    // Scoreboard of accepted bytes, producer = model, consumer = line decoder.
    logic [7:0] sb_q  [2][64];
    int         sb_wr [2] = '{0, 0};
    int         sb_rd [2] = '{0, 0};

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    logic final_req = 1'b0;
    logic final_done = 1'b0;

    function automatic int frame_len(input int i);
        return (10 + i) * C;  // start + 8 data + (i+1) stop bits
    endfunction

    function automatic logic model_tx(input int i);
        int t;
        int b;
        if (m_cyc[i] == 0) return 1'b1;
        t = frame_len(i) - m_cyc[i];
        b = t / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[i][b-1];
        return 1'b1;
    endfunction

    always @(posedge clkin) begin
        logic popf;
        logic acc;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_head[i] = 0;
                m_cnt[i]  = 0;
                m_cyc[i]  = 0;
                m_ovf[i]  = 1'b0;
            end else begin
                if (m_cyc[i] > 0) m_cyc[i]--;
                popf = (m_cyc[i] == 0) && (m_cnt[i] > 0);
                acc  = push_valid[i] && ((m_cnt[i] < D) || popf);
                if (popf) begin
                    m_cur[i]  = m_buf[i][m_head[i]];
                    m_head[i] = (m_head[i] + 1) % D;
                    m_cnt[i]--;
                    m_cyc[i]  = frame_len(i);
                end
                if (acc) begin
                    m_buf[i][(m_head[i] + m_cnt[i]) % D] = push_data[i];
                    m_cnt[i]++;
                    sb_q[i][sb_wr[i] % 64] = push_data[i];
                    sb_wr[i]++;
                end else if (push_valid[i]) begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, i, $time, act, exp_v);
        end
    endtask

    // Monitor: per-cycle flag/line comparison plus an independent line decoder.
    logic       mon_act  [2] = '{1'b0, 1'b0};
    int         mon_cnt  [2] = '{0, 0};
    logic [7:0] mon_byte [2];

    always @(negedge clkin) begin
        int c;
        int b;
        logic [7:0] exp_b;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                chk("rst_uart_tx", i, int'(uart_tx[i]), 1);
                chk("rst_level", i, int'(fifo_level[i]), 0);
                chk("rst_full", i, int'(fifo_full[i]), 0);
                chk("rst_overflow", i, int'(overflow[i]), 0);
                chk("rst_busy", i, int'(tx_busy[i]), 0);
                mon_act[i] = 1'b0;
                sb_rd[i]   = sb_wr[i];
            end else begin
                chk("uart_tx", i, int'(uart_tx[i]), int'(model_tx(i)));
                chk("level", i, int'(fifo_level[i]), m_cnt[i]);
                chk("full", i, int'(fifo_full[i]), int'(m_cnt[i] == D));
                chk("overflow", i, int'(overflow[i]), int'(m_ovf[i]));
                chk("busy", i, int'(tx_busy[i]), int'((m_cyc[i] > 0) || (m_cnt[i] > 0)));

                if (!mon_act[i] && !uart_tx[i]) begin
                    mon_act[i] = 1'b1;
                    mon_cnt[i] = 0;
                end
                if (mon_act[i]) begin
                    c = mon_cnt[i];
                    if (c == C / 2) begin
                        chk("start_bit", i, int'(uart_tx[i]), 0);
                    end else if ((c > C) && (((c - C / 2) % C) == 0)) begin
                        b = (c - C / 2) / C;
                        if (b <= 8) mon_byte[i][b-1] = uart_tx[i];
                        else chk("stop_bit", i, int'(uart_tx[i]), 1);
                    end
                    if (c == frame_len(i) - 1) begin
                        chk("frame_expected", i, int'(sb_wr[i] > sb_rd[i]), 1);
                        if (sb_wr[i] > sb_rd[i]) begin
                            exp_b = sb_q[i][sb_rd[i] % 64];
                            sb_rd[i]++;
                            chk("frame_byte", i, int'(mon_byte[i]), int'(exp_b));
                        end
                        mon_act[i] = 1'b0;
                    end
                    mon_cnt[i]++;
                end
            end
        end
        if (final_req && !final_done) begin
            for (int i = 0; i < 2; i++) begin
                chk("frames_pending", i, sb_wr[i] - sb_rd[i], 0);
            end
            chk("wait_timeouts", 0, to_cnt, 0);
            final_done = 1'b1;
        end
    end

    task automatic step();
        @(negedge clkin);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        push_valid   = v;
        push_data[0] = d0;
        push_data[1] = d1;
        step();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!((m_cyc[0] == 0) && (m_cnt[0] == 0) && (m_cyc[1] == 0) && (m_cnt[1] == 0))) begin
            if (n >= limit) begin
                to_cnt++;
                return;
            end
            step();
            n++;
        end
        step();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        int rate;
        logic [1:0] v;

        repeat (3) @(negedge clkin);
        #1 reset_n = 1'b1;
        step();

        // Single byte
        drive(2'b11, 8'hA5, 8'hA5);
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(200);

        // Back-to-back frames
        drive(2'b11, 8'h00, 8'h00);
        drive(2'b11, 8'hFF, 8'hFF);
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(300);

        // Overflow: 6 pushes from idle, the sixth is dropped
        for (int k = 1; k <= 6; k++) drive(2'b11, 8'(k), 8'(k));
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(500);
        apply_reset();

        // Full FIFO accepts a push on the pop edge
        for (int k = 0; k < 5; k++) drive(2'b01, 8'(8'h10 + k), 8'h00);
        push_valid = '0;
        n = 0;
        while (m_cyc[0] != 1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) to_cnt++;
        drive(2'b01, 8'h77, 8'h00);
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(500);

        // Reset during data bit 3
        drive(2'b11, 8'hC3, 8'hC3);
        push_valid = '0;
        n = 0;
        while (!((m_cyc[0] > 0) && ((frame_len(0) - m_cyc[0]) / C == 4)) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) to_cnt++;
        apply_reset();
        drive(2'b11, 8'h3C, 8'h3C);
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(200);

        // Two queued bytes: stop-bit length sets the inter-frame spacing
        drive(2'b11, 8'h55, 8'h55);
        drive(2'b11, 8'hAA, 8'hAA);
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(300);

        // Random traffic at a light then heavy load, with one reset mid-run
        for (n = 0; n < 3000; n++) begin
            rate = (n < 1500) ? 3 : 40;
            v[0] = ($urandom_range(0, 99) < rate);
            v[1] = ($urandom_range(0, 99) < rate);
            if (n == 2200) apply_reset();
            drive(v, 8'($urandom), 8'($urandom));
        end
        drive(2'b00, 8'h00, 8'h00);
        wait_idle(1000);

        final_req = 1'b1;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
